// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: state encoding and sizing constants.
package div_radix2_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_radix2_if.sv
// E-stage <-> divider handshake: operands and control in, {HI, LO} result, ready and stall out.
interface div_radix2_if #(
  parameter int WIDTH = div_radix2_pkg::DIV_WIDTH
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stall_div;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stall_div
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stall_div
  );
endinterface

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract the divisor from rem.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]     diff;

  always_comb begin
    // NOTE: every output gets a default before the conditional update, so no latch is inferred.
    shifted  = {acc[2*WIDTH-2:0], 1'b0};
    diff     = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    acc_next = shifted;
    if (!diff[WIDTH]) begin
      acc_next = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle 32-bit radix-2 restoring divider for MIPS DIV/DIVU (result = {HI, LO}).
// Optional feature: define DIV_ZERO_SHORTCUT_EN to finish a divide-by-zero in two cycles with result 0.
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         resetn,
  div_radix2_if.slave  bus
);

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 dvd_neg;
  logic                 dvs_neg;
  logic [WIDTH-1:0]     divisor;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  logic [WIDTH-1:0]     dvd_mag;
  logic [WIDTH-1:0]     dvs_mag;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude 2^31.
  assign dvd_mag = (bus.signed_div && bus.opdata1[WIDTH-1]) ? (~bus.opdata1 + WIDTH'(1)) : bus.opdata1;
  assign dvs_mag = (bus.signed_div && bus.opdata2[WIDTH-1]) ? (~bus.opdata2 + WIDTH'(1)) : bus.opdata2;

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .divisor  (divisor),
    .acc_next (acc_next)
  );

  // Sign fix applied to the final iteration's output as it is registered into result.
  assign quot_fix = (dvd_neg ^ dvs_neg) ? (~acc_next[WIDTH-1:0] + WIDTH'(1)) : acc_next[WIDTH-1:0];
  assign rem_fix  = dvd_neg ? (~acc_next[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_next[2*WIDTH-1:WIDTH];

  // An annul in the END cycle suppresses the pulse the pipeline would otherwise see.
  assign bus.ready     = ready_q & ~bus.annul;
  assign bus.result    = result_q;
  assign bus.stall_div = bus.start & ~bus.ready & ~bus.annul;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd_neg  <= 1'b0;
      dvs_neg  <= 1'b0;
      divisor  <= '0;
      acc      <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else if (bus.annul) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update here see pre-edge values.
      ready_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_neg <= bus.signed_div & bus.opdata1[WIDTH-1];
            dvs_neg <= bus.signed_div & bus.opdata2[WIDTH-1];
            divisor <= dvs_mag;
            acc     <= {{WIDTH{1'b0}}, dvd_mag};
            cnt     <= '0;
`ifdef DIV_ZERO_SHORTCUT_EN
            state   <= (dvs_mag == '0) ? DIVZERO : ON;
`else
            state   <= ON;
`endif
          end
        end
        DIVZERO: begin
`ifdef DIV_ZERO_SHORTCUT_EN
          result_q <= '0;
          ready_q  <= 1'b1;
          state    <= END;
`else
          state    <= IDLE;
`endif
        end
        ON: begin
          acc <= acc_next;
          if (cnt == DIV_CNT_W'(WIDTH - 1)) begin
            cnt      <= '0;
            result_q <= {rem_fix, quot_fix};
            ready_q  <= 1'b1;
            state    <= END;
          end else begin
            cnt <= cnt + DIV_CNT_W'(1);
          end
        end
        END: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Scoreboard bench for div_radix2: expected {HI, LO} queued at issue, popped on each ready pulse.
module tb_div_radix2;

  logic clk;
  logic resetn;

  div_radix2_if bus ();

  div_radix2 dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_result;

  // Reference: built from native 64-bit arithmetic, independent of the shift/subtract datapath.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_SHORTCUT_EN
      return 64'd0;
`else
      // Magnitude quotient is all ones; signs differ only when a signed dividend is negative.
      return {a, ((s && a[31]) ? 32'd1 : 32'hFFFF_FFFF)};
`endif
    end
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int latency(input logic [31:0] b);
`ifdef DIV_ZERO_SHORTCUT_EN
    return (b == 32'd0) ? 2 : 33;
`else
    return 33 + int'(b == 32'd0) * 0;
`endif
  endfunction

  // Issues one division in the current cycle (cycle 0) and follows it to its ready pulse.
  // Leaves the bench at the start of the cycle after ready.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit keep_start, input string name);
    int          lat;
    bit          got;
    logic [63:0] exp;
    lat = latency(b);
    exp_q.push_back(model(a, b, s));
    bus.start      = 1'b1;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.signed_div = s;
    got = 1'b0;
    for (int c = 0; c <= lat + 3 && !got; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.stall_div !== (c < lat)) begin
        n_fail++;
        $display("FAIL %s stall_div cycle %0d: got %b want %b", name, c, bus.stall_div, (c < lat));
      end
      if (bus.ready === 1'b1) begin
        got = 1'b1;
        exp = exp_q.pop_front();
        n_checks++;
        if (c != lat) begin
          n_fail++;
          $display("FAIL %s ready cycle: got %0d want %0d", name, c, lat);
        end
        n_checks++;
        if (bus.result !== exp) begin
          n_fail++;
          $display("FAIL %s result: got %h want %h", name, bus.result, exp);
        end
        last_result = exp;
      end
      @(posedge clk);
      #1;
      // Operands change after capture; the divider must ignore them.
      if (c == 0) begin
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.signed_div = ~s;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: no ready within %0d cycles", name, lat + 3);
      void'(exp_q.pop_front());
    end
    if (!keep_start) bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    resetn         = 1'b0;
    last_result    = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b result=%h want 0/0", bus.ready, bus.result);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.stall_div !== 1'b0 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got stall=%b ready=%b want 0/0", bus.stall_div, bus.ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu_basic();
    do_div(32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_after_ready: got ready=%b want 0", bus.ready);
    end
    n_checks++;
    if (last_result !== {32'd2, 32'd14}) begin
      n_fail++;
      $display("FAIL divu_100_7_const: got %h want %h", last_result, {32'd2, 32'd14});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_signed();
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_m7_2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_overflow");
    n_checks++;
    if (last_result !== {32'd0, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL div_overflow_const: got %h want %h", last_result, {32'd0, 32'h8000_0000});
    end
    do_div(32'd1000, 32'hFFFF_FFF9, 1'b1, 1'b0, "div_pos_neg");
    do_div(32'h8000_0000, 32'd3, 1'b0, 1'b0, "divu_msb");
    for (int i = 0; i < 3; i++) begin
      do_div($urandom, $urandom_range(1, 32'hFFFF), i[0], 1'b0, "div_random");
    end
  endtask

  task automatic test_back_to_back();
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, "b2b_first");
    do_div(32'd9, 32'hFFFF_FFFD, 1'b1, 1'b0, "b2b_second");
    n_checks++;
    if (last_result !== {32'd0, 32'hFFFF_FFFD}) begin
      n_fail++;
      $display("FAIL b2b_second_const: got %h want %h", last_result, {32'd0, 32'hFFFF_FFFD});
    end
  endtask

  task automatic test_annul();
    logic [63:0] held;
    int          pulses;
    held           = last_result;
    pulses         = 0;
    bus.start      = 1'b1;
    bus.opdata1    = 32'd500;
    bus.opdata2    = 32'd3;
    bus.signed_div = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.annul = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.stall_div !== 1'b0) begin
      n_fail++;
      $display("FAIL annul_stall: got %b want 0", bus.stall_div);
    end
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL annul_no_ready: got %0d pulses want 0", pulses);
    end
    n_checks++;
    if (bus.result !== held) begin
      n_fail++;
      $display("FAIL annul_result_held: got %h want %h", bus.result, held);
    end
    @(posedge clk);
    #1;
    do_div(32'd500, 32'd3, 1'b0, 1'b0, "annul_restart");
  endtask

  task automatic test_div_zero();
    do_div(32'd5, 32'd0, 1'b0, 1'b0, "divu_5_0");
    do_div(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, "div_m7_0");
  endtask

  task automatic test_reset_mid_op();
    bus.start      = 1'b1;
    bus.opdata1    = 32'd77;
    bus.opdata2    = 32'd5;
    bus.signed_div = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    #1;
    resetn    = 1'b0;
    bus.start = 1'b0;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got ready=%b result=%h want 0/0", bus.ready, bus.result);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    do_div(32'd8, 32'd2, 1'b0, 1'b0, "after_reset_8_2");
    n_checks++;
    if (last_result !== {32'd0, 32'd4}) begin
      n_fail++;
      $display("FAIL after_reset_const: got %h want %h", last_result, {32'd0, 32'd4});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_back_to_back();
    test_annul();
    test_div_zero();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
